// File: rtl/pipe_skid_stage_pkg.sv
// Shared types and constants for the pipeline stage registers.
// The default payload width is taken from the stage payload struct.
package pipe_skid_stage_pkg;

  typedef struct packed {
    logic [15:0] pc_plus2;
    logic [15:0] instruction;
    logic [15:0] ctrl_word;
  } lc3b_stage_payload;

  localparam int unsigned PIPE_CNT_W = 16;
  localparam int unsigned PIPE_WIDTH = $bits(lc3b_stage_payload);

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready handshake bundle for one pipeline stage (upstream and downstream sides).
// The stage connects through the slave modport; the producer/consumer side uses master.
interface pipe_skid_stage_if
  import pipe_skid_stage_pkg::*;
#(
  parameter int unsigned WIDTH = PIPE_WIDTH
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_skid_stage_entry_reg.sv
// One valid+data entry. Clear drops the valid bit and keeps the data;
// load captures new data. Clear has priority over load.
module pipe_entry_reg
  import pipe_skid_stage_pkg::*;
#(
  parameter int unsigned WIDTH = PIPE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             v_o,
  output logic [WIDTH-1:0] q_o
);
  logic             v_q, v_d;
  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    v_d = v_q;
    q_d = q_q;
    if (clr_i) begin
      v_d = 1'b0;
    end else if (load_i) begin
      v_d = 1'b1;
      q_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      q_q <= '0;
    end else begin
      v_q <= v_d;
      q_q <= q_d;
    end
  end

  assign v_o = v_q;
  assign q_o = q_q;
endmodule

// File: rtl/pipe_skid_stage.sv
// Inter-stage register with valid/ready backpressure, a one-entry skid buffer,
// flush, and a saturating count of cycles spent stalled with valid output.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int unsigned WIDTH = PIPE_WIDTH,
  parameter int unsigned CNT_W = PIPE_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  pipe_skid_stage_if.slave bus,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt
);
  logic             main_v, skid_v;
  logic [WIDTH-1:0] main_d, skid_d;
  logic             acc, drn, main_free;
  logic             main_clr, main_load, skid_clr, skid_load;
  logic [WIDTH-1:0] main_src;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // in_ready comes from the skid register alone, so out_ready never reaches it.
  assign bus.in_ready  = !skid_v;
  assign bus.out_valid = main_v;
  assign bus.out_data  = main_d;

  assign acc       = bus.in_valid & !skid_v;
  assign drn       = main_v & bus.out_ready;
  assign main_free = !main_v | drn;

  // Main refills from skid first to keep FIFO order; skid loads only when main is stuck.
  assign main_src  = skid_v ? skid_d : bus.in_data;
  assign main_load = !flush & main_free & (skid_v | acc);
  assign main_clr  = flush | (main_free & !skid_v & !acc);
  assign skid_load = !flush & !main_free & acc;
  assign skid_clr  = flush | (main_free & skid_v);

  pipe_entry_reg #(.WIDTH(WIDTH)) u_main (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (main_clr),
    .load_i (main_load),
    .d_i    (main_src),
    .v_o    (main_v),
    .q_o    (main_d)
  );

  pipe_entry_reg #(.WIDTH(WIDTH)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (skid_clr),
    .load_i (skid_load),
    .d_i    (bus.in_data),
    .v_o    (skid_v),
    .q_o    (skid_d)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (main_v && !bus.out_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and randomized bench for pipe_skid_stage, checked against a
// queue-based occupancy model and a saturating counter model.
module tb_pipe_skid_stage;
  localparam int unsigned W  = 48;
  localparam int unsigned CW = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] stall_cnt;

  pipe_skid_stage_if #(.WIDTH(W)) bus ();

  pipe_skid_stage #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .flush     (flush),
    .cnt_clr   (cnt_clr),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [W-1:0] q_m[$];
  int unsigned  cnt_m = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model at posedge.
  task automatic step(input logic r, input logic iv, input logic [W-1:0] d,
                      input logic ordy, input logic fl, input logic clr, input bit do_chk);
    bit drn_m, acc_m;
    @(negedge clk);
    rst = r;
    bus.in_valid = iv;
    bus.in_data = d;
    bus.out_ready = ordy;
    flush = fl;
    cnt_clr = clr;
    if (do_chk) begin
      chk("out_valid", 64'(bus.out_valid), 64'(q_m.size() > 0));
      chk("in_ready", 64'(bus.in_ready), 64'(q_m.size() < 2));
      chk("stall_cnt", 64'(stall_cnt), 64'(cnt_m));
      if (q_m.size() > 0) chk("out_data", 64'(bus.out_data), 64'(q_m[0]));
      chk("skid_implies_main", 64'(bus.in_ready || bus.out_valid), 64'(1));
    end
    @(posedge clk);
    if (r) begin
      q_m.delete();
      cnt_m = 0;
    end else begin
      if (clr) cnt_m = 0;
      else if (q_m.size() > 0 && !ordy && cnt_m < CMAX) cnt_m++;
      if (fl) begin
        q_m.delete();
      end else begin
        drn_m = (q_m.size() > 0) && ordy;
        acc_m = iv && (q_m.size() < 2);
        if (drn_m) void'(q_m.pop_front());
        if (acc_m) q_m.push_back(d);
      end
    end
    #1;
  endtask

  initial begin
    logic [W-1:0] rd;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;

    // Reset for two cycles, then check the idle state.
    step(1, 0, '0, 0, 0, 0, 0);
    step(1, 0, '0, 0, 0, 0, 0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));

    // Full-rate stream.
    step(0, 1, 48'h111, 1, 0, 0, 1);
    chk("stream_111", 64'(bus.out_data), 64'h111);
    step(0, 1, 48'h222, 1, 0, 0, 1);
    chk("stream_222", 64'(bus.out_data), 64'h222);
    step(0, 1, 48'h333, 1, 0, 0, 1);
    chk("stream_333", 64'(bus.out_data), 64'h333);
    chk("stream_ready", 64'(bus.in_ready), 64'(1));
    step(0, 0, '0, 1, 0, 0, 1);
    chk("stream_cnt", 64'(stall_cnt), 64'(0));

    // Backpressure fills the skid entry.
    step(0, 1, 48'hA, 0, 0, 0, 1);
    step(0, 1, 48'hB, 0, 0, 0, 1);
    chk("bp_out_A", 64'(bus.out_data), 64'hA);
    chk("bp_ready0", 64'(bus.in_ready), 64'(0));
    chk("bp_cnt1", 64'(stall_cnt), 64'(1));
    step(0, 0, '0, 0, 0, 0, 1);
    chk("bp_cnt2", 64'(stall_cnt), 64'(2));
    step(0, 0, '0, 1, 0, 0, 1);
    chk("bp_out_B", 64'(bus.out_data), 64'hB);
    chk("bp_ready1", 64'(bus.in_ready), 64'(1));
    step(0, 0, '0, 1, 0, 0, 1);
    chk("bp_empty", 64'(bus.out_valid), 64'(0));

    // Flush with both entries full and a new payload offered.
    step(0, 1, 48'hA, 0, 0, 0, 1);
    step(0, 1, 48'hB, 0, 0, 0, 1);
    step(0, 1, 48'hC, 0, 1, 0, 1);
    chk("flush_valid", 64'(bus.out_valid), 64'(0));
    chk("flush_ready", 64'(bus.in_ready), 64'(1));
    step(0, 0, '0, 1, 0, 0, 1);
    step(0, 0, '0, 1, 0, 0, 1);

    // Simultaneous drain and accept keeps skid empty.
    step(0, 1, 48'h77, 0, 0, 0, 1);
    step(0, 1, 48'hD, 1, 0, 0, 1);
    chk("da_out_D", 64'(bus.out_data), 64'hD);
    chk("da_ready", 64'(bus.in_ready), 64'(1));

    // Counter saturation, then clear beats increment.
    step(0, 0, '0, 0, 0, 1, 1);
    for (int i = 0; i < 20; i++) step(0, 0, '0, 0, 0, 0, 1);
    chk("cnt_sat", 64'(stall_cnt), 64'(CMAX));
    step(0, 0, '0, 0, 0, 1, 1);
    chk("cnt_clr", 64'(stall_cnt), 64'(0));

    // Reset during a stall with both entries full.
    step(0, 1, 48'hE, 0, 0, 0, 1);
    step(0, 0, '0, 0, 0, 0, 1);
    chk("pre_rst_full", 64'(bus.in_ready), 64'(0));
    step(1, 0, '0, 0, 0, 0, 1);
    chk("mrst_valid", 64'(bus.out_valid), 64'(0));
    chk("mrst_ready", 64'(bus.in_ready), 64'(1));
    chk("mrst_cnt", 64'(stall_cnt), 64'(0));
    step(0, 1, 48'h5, 1, 0, 0, 1);
    chk("mrst_out_5", 64'(bus.out_data), 64'h5);
    step(0, 0, '0, 1, 0, 0, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rd = {$urandom(), $urandom()} & {W{1'b1}};
      step(($urandom_range(99) == 0), $urandom_range(1), rd, ($urandom_range(2) != 0),
           ($urandom_range(19) == 0), ($urandom_range(29) == 0), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
